// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: round-robin share of one Avalon-MM SDRAM master port between two requesters.
// Latency: grant is registered (command on sdram_* one cycle after request); read-return steering is combinational.
// Backpressure: owner sees sdram_waitrequest; non-owner, and a read owner facing a full tag FIFO, see waitrequest=1.
//
// Ports:
//   clk_clk, reset_reset_n         : clock, async active-low reset
//   m0_* / m1_*                    : requester-side Avalon-MM slaves (cmd in, waitrequest/readdata out)
//   sdram_*                        : master toward the soc_system SDRAM slave
module sdram_port_arbiter #(
  parameter int ADDR_W   = 29,
  parameter int DATA_W   = 64,
  parameter int BURST_W  = 8,
  parameter int MAX_PEND = 4
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic [BURST_W-1:0]    m0_burstcount,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic [BURST_W-1:0]    m1_burstcount,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [ADDR_W-1:0]     sdram_address,
  output logic [DATA_W-1:0]     sdram_writedata,
  output logic [DATA_W/8-1:0]   sdram_byteenable,
  output logic [BURST_W-1:0]    sdram_burstcount,
  output logic                  sdram_read,
  output logic                  sdram_write,
  input  logic                  sdram_waitrequest,
  input  logic [DATA_W-1:0]     sdram_readdata,
  input  logic                  sdram_readdatavalid
);

  // MAX_PEND is a power of two (>= 2) so the pointers wrap on their own.
  localparam int PTR_W = $clog2(MAX_PEND);
  localparam int CNT_W = $clog2(MAX_PEND + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_WBURST} state_t;

  typedef struct packed {
    logic               owner;
    logic [BURST_W-1:0] beats;   // already normalised: never 0
  } tag_t;

  state_t             state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_grant_q, last_grant_d;
  logic [BURST_W-1:0] wcnt_q, wcnt_d;
  logic [BURST_W-1:0] rrem_q, rrem_d;
  tag_t               tag_mem_q [MAX_PEND];
  tag_t               tag_mem_d [MAX_PEND];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               req0, req1;
  logic               own_read, own_write, own_wait;
  logic [ADDR_W-1:0]  own_addr;
  logic [DATA_W-1:0]  own_wdata;
  logic [DATA_W/8-1:0] own_be;
  logic [BURST_W-1:0] own_bc, own_beats;
  logic               fifo_empty, fifo_full, push, pop, rd_blocked;
  tag_t               head;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  assign own_read  = owner_q ? m1_read       : m0_read;
  assign own_write = owner_q ? m1_write      : m0_write;
  assign own_addr  = owner_q ? m1_address    : m0_address;
  assign own_wdata = owner_q ? m1_writedata  : m0_writedata;
  assign own_be    = owner_q ? m1_byteenable : m0_byteenable;
  assign own_bc    = owner_q ? m1_burstcount : m0_burstcount;
  // A burstcount of 0 is handled as a single beat everywhere.
  assign own_beats = (own_bc == '0) ? BURST_W'(1) : own_bc;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(MAX_PEND));
  assign head       = tag_mem_q[rd_ptr_q];

  // Read return: fan data out, steer valid by the oldest tag. Beats arriving
  // with no tag outstanding (e.g. left over from before a reset) are dropped.
  assign m0_readdata      = sdram_readdata;
  assign m1_readdata      = sdram_readdata;
  assign m0_readdatavalid = sdram_readdatavalid & ~fifo_empty & ~head.owner;
  assign m1_readdatavalid = sdram_readdatavalid & ~fifo_empty &  head.owner;

  always_comb begin
    rrem_d = rrem_q;
    pop    = 1'b0;
    if (sdram_readdatavalid && !fifo_empty) begin
      // rrem_q==0 means this is the first beat of the head burst.
      if (rrem_q == '0) begin
        rrem_d = head.beats - 1'b1;
      end else begin
        rrem_d = rrem_q - 1'b1;
      end
      pop = (rrem_d == '0);
    end
  end

  // A pop in the same cycle frees a slot, so a stalled read may issue alongside it.
  assign rd_blocked = fifo_full & ~pop;

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    last_grant_d     = last_grant_q;
    wcnt_d           = wcnt_q;
    push             = 1'b0;
    own_wait         = 1'b1;
    sdram_address    = '0;
    sdram_writedata  = '0;
    sdram_byteenable = '0;
    sdram_burstcount = '0;
    sdram_read       = 1'b0;
    sdram_write      = 1'b0;
    m0_waitrequest   = 1'b1;
    m1_waitrequest   = 1'b1;

    if (state_q != ST_IDLE) begin
      sdram_address    = own_addr;
      sdram_writedata  = own_wdata;
      sdram_byteenable = own_be;
      sdram_burstcount = own_bc;
    end

    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          owner_d      = (req0 && req1) ? ~last_grant_q : req1;
          last_grant_d = owner_d;
          state_d      = ST_CMD;
        end
      end
      ST_CMD: begin
        if (own_read) begin
          sdram_read = ~rd_blocked;
          own_wait   = rd_blocked | sdram_waitrequest;
          if (!rd_blocked && !sdram_waitrequest) begin
            push    = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          sdram_write = own_write;
          own_wait    = sdram_waitrequest;
          if (own_write && !sdram_waitrequest) begin
            if (own_beats == BURST_W'(1)) begin
              state_d = ST_IDLE;
            end else begin
              wcnt_d  = own_beats - 1'b1;
              state_d = ST_WBURST;
            end
          end
        end
      end
      ST_WBURST: begin
        // Owner dropping write mid-burst simply produces no beat.
        sdram_write = own_write;
        own_wait    = sdram_waitrequest;
        if (own_write && !sdram_waitrequest) begin
          wcnt_d = wcnt_q - 1'b1;
          if (wcnt_q == BURST_W'(1)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_IDLE) begin
      if (owner_q) m1_waitrequest = own_wait;
      else         m0_waitrequest = own_wait;
    end
  end

  always_comb begin
    tag_mem_d = tag_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push) begin
      tag_mem_d[wr_ptr_q].owner = owner_q;
      tag_mem_d[wr_ptr_q].beats = own_beats;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;   // requester 0 wins the first tie
      wcnt_q       <= '0;
      rrem_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      for (int i = 0; i < MAX_PEND; i++) tag_mem_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      wcnt_q       <= wcnt_d;
      rrem_q       <= rrem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      for (int i = 0; i < MAX_PEND; i++) tag_mem_q[i] <= tag_mem_d[i];
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed boundary cases plus randomized two-requester traffic
// against a transaction-level SDRAM slave model that tracks issued commands and returns reads in order.
`timescale 1ns/1ps
module tb_sdram_port_arbiter;
  localparam int ADDR_W   = 29;
  localparam int DATA_W   = 64;
  localparam int BURST_W  = 8;
  localparam int MAX_PEND = 4;
  localparam int BE_W     = DATA_W / 8;
  localparam int NTR      = 40;

  typedef struct packed {
    logic        id;
    logic [15:0] seq;
    logic [8:0]  beats;
  } job_t;

  logic clk_clk = 1'b0;
  logic reset_reset_n;
  logic [1:0]         m_read, m_write, m_wait, m_rdv;
  logic [ADDR_W-1:0]  m_addr  [2];
  logic [DATA_W-1:0]  m_wdata [2];
  logic [DATA_W-1:0]  m_rdata [2];
  logic [BE_W-1:0]    m_be    [2];
  logic [BURST_W-1:0] m_bc    [2];
  logic [ADDR_W-1:0]  sdram_address;
  logic [DATA_W-1:0]  sdram_writedata;
  logic [BE_W-1:0]    sdram_byteenable;
  logic [BURST_W-1:0] sdram_burstcount;
  logic               sdram_read, sdram_write;
  logic               sdram_waitrequest, sdram_readdatavalid;
  logic [DATA_W-1:0]  sdram_readdata;

  always #5 clk_clk = ~clk_clk;

  sdram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W), .MAX_PEND(MAX_PEND)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .m0_address(m_addr[0]), .m0_read(m_read[0]), .m0_write(m_write[0]),
    .m0_writedata(m_wdata[0]), .m0_byteenable(m_be[0]), .m0_burstcount(m_bc[0]),
    .m0_waitrequest(m_wait[0]), .m0_readdata(m_rdata[0]), .m0_readdatavalid(m_rdv[0]),
    .m1_address(m_addr[1]), .m1_read(m_read[1]), .m1_write(m_write[1]),
    .m1_writedata(m_wdata[1]), .m1_byteenable(m_be[1]), .m1_burstcount(m_bc[1]),
    .m1_waitrequest(m_wait[1]), .m1_readdata(m_rdata[1]), .m1_readdatavalid(m_rdv[1]),
    .sdram_address(sdram_address), .sdram_writedata(sdram_writedata),
    .sdram_byteenable(sdram_byteenable), .sdram_burstcount(sdram_burstcount),
    .sdram_read(sdram_read), .sdram_write(sdram_write),
    .sdram_waitrequest(sdram_waitrequest), .sdram_readdata(sdram_readdata),
    .sdram_readdatavalid(sdram_readdatavalid)
  );

  int checks = 0;
  int errors = 0;

  // Reference-model state for the random phase.
  bit                 tr_wr [2][NTR];
  logic [BURST_W-1:0] tr_bc [2][NTR];
  int                 sidx [2];
  int                 rx [2];
  int                 exp_rx [2];
  bit [1:0]           done;
  bit                 stop;
  bit                 ret_busy;
  int                 wr_rem, cur_id, cur_seq, cur_beat;
  job_t               rq [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [ADDR_W-1:0] exp_addr(input int id, input int seq);
    return {id[0], (ADDR_W-1)'(seq)};
  endfunction

  function automatic logic [DATA_W-1:0] wdat(input int id, input int seq, input int b);
    return {8'hA0 | 8'(id), 24'(seq), 32'(b)};
  endfunction

  function automatic logic [DATA_W-1:0] rdat(input int id, input int seq, input int b);
    return {8'h50 | 8'(id), 24'(seq), 32'(b)};
  endfunction

  function automatic int eff(input logic [BURST_W-1:0] bc);
    return (bc == '0) ? 1 : int'(bc);
  endfunction

  task automatic cyc();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic idle_inputs();
    m_read = '0;
    m_write = '0;
    for (int i = 0; i < 2; i++) begin
      m_addr[i] = '0; m_wdata[i] = '0; m_be[i] = '1; m_bc[i] = 1;
    end
    sdram_waitrequest = 1'b0;
    sdram_readdatavalid = 1'b0;
    sdram_readdata = '0;
  endtask

  task automatic do_reset();
    reset_reset_n = 1'b0;
    idle_inputs();
    cyc(); cyc();
    reset_reset_n = 1'b1;
    cyc();
  endtask

  task automatic run_req(input int id);
    int   beats, guard;
    logic ok;
    for (int i = 0; i < NTR; i++) begin
      repeat ($urandom_range(0, 2)) cyc();
      beats = eff(tr_bc[id][i]);
      m_addr[id] = exp_addr(id, i);
      m_bc[id] = tr_bc[id][i];
      m_be[id] = '1;
      for (int b = 0; b < beats; b++) begin
        m_wdata[id] = wdat(id, i, b);
        guard = 0;
        forever begin
          if (tr_wr[id][i]) m_write[id] = (b == 0) || ($urandom_range(0, 3) != 0);
          else              m_read[id] = 1'b1;
          @(negedge clk_clk);
          ok = (m_write[id] || m_read[id]) && !m_wait[id];
          cyc();
          if (ok) break;
          guard++;
          if (guard > 3000) begin
            chk("req_timeout", guard, 0);
            break;
          end
        end
        if (!tr_wr[id][i]) break;
      end
      m_read[id] = 1'b0;
      m_write[id] = 1'b0;
    end
    done[id] = 1'b1;
  endtask

  task automatic run_slave();
    int   id, seq;
    job_t j;
    while (!stop) begin
      sdram_waitrequest = ($urandom_range(0, 3) == 0);
      @(negedge clk_clk);
      if ((sdram_read || sdram_write) && !sdram_waitrequest) begin
        if (wr_rem > 0) begin
          chk("wr_cont", {sdram_read, sdram_write}, 2'b01);
          chk("wr_data", sdram_writedata, wdat(cur_id, cur_seq, cur_beat));
          cur_beat++;
          wr_rem--;
        end else begin
          id  = int'(sdram_address[ADDR_W-1]);
          seq = sidx[id];
          chk("cmd_seq", seq < NTR, 1);
          if (seq < NTR) begin
            chk("cmd_addr", sdram_address, exp_addr(id, seq));
            chk("cmd_type", sdram_write, tr_wr[id][seq]);
            chk("cmd_bc", sdram_burstcount, tr_bc[id][seq]);
            sidx[id]++;
            if (tr_wr[id][seq]) begin
              chk("wr_data0", sdram_writedata, wdat(id, seq, 0));
              chk("wr_be", sdram_byteenable, {BE_W{1'b1}});
              wr_rem   = eff(tr_bc[id][seq]) - 1;
              cur_id   = id;
              cur_seq  = seq;
              cur_beat = 1;
            end else begin
              j.id = id[0];
              j.seq = 16'(seq);
              j.beats = 9'(eff(tr_bc[id][seq]));
              rq.push_back(j);
            end
          end
        end
      end
      cyc();
    end
  endtask

  task automatic run_ret();
    job_t j;
    while (!stop) begin
      if (rq.size() == 0) begin
        @(negedge clk_clk);
        chk("rdv_idle", m_rdv, 2'b00);
        cyc();
      end else begin
        ret_busy = 1'b1;
        j = rq.pop_front();
        repeat ($urandom_range(0, 3)) cyc();
        for (int b = 0; b < int'(j.beats); b++) begin
          if ($urandom_range(0, 3) == 0) cyc();
          sdram_readdatavalid = 1'b1;
          sdram_readdata = rdat(int'(j.id), int'(j.seq), b);
          @(negedge clk_clk);
          chk("rd_route", m_rdv, j.id ? 2'b10 : 2'b01);
          chk("rd_data", m_rdata[j.id], rdat(int'(j.id), int'(j.seq), b));
          rx[j.id] += 1;
          cyc();
          sdram_readdatavalid = 1'b0;
        end
        ret_busy = 1'b0;
      end
    end
  endtask

  initial begin
    int guard;
    logic acc;

    // Reset held with both requesters active and a stray readdatavalid.
    reset_reset_n = 1'b0;
    idle_inputs();
    m_read = 2'b11;
    m_addr[0] = exp_addr(0, 100);
    m_addr[1] = exp_addr(1, 200);
    sdram_readdatavalid = 1'b1;
    repeat (3) cyc();
    @(negedge clk_clk);
    chk("rst_wait", m_wait, 2'b11);
    chk("rst_sdram_rd", sdram_read, 0);
    chk("rst_sdram_wr", sdram_write, 0);
    chk("rst_rdv", m_rdv, 2'b00);
    chk("rst_addr", sdram_address, 0);
    cyc();
    m_read = 2'b00;
    sdram_readdatavalid = 1'b0;
    reset_reset_n = 1'b1;
    cyc(); cyc();

    // Tie: m0 first, then strict alternation, one accept every 2 cycles.
    m_read = 2'b11;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_clk);
      acc = sdram_read && !sdram_waitrequest;
      chk("arb_acc", acc, k % 2);
      if (k % 2 == 1) begin
        chk("arb_owner", sdram_address[ADDR_W-1], (k / 2) % 2);
        chk("arb_wait", m_wait, ((k / 2) % 2 == 1) ? 2'b01 : 2'b10);
      end
      cyc();
    end
    // Four tags now outstanding: the fifth read must stall.
    m_read = 2'b01;
    for (int k = 8; k < 12; k++) begin
      @(negedge clk_clk);
      if (k > 8) begin
        chk("full_rd", sdram_read, 0);
        chk("full_wait", m_wait[0], 1);
      end
      cyc();
    end
    sdram_readdatavalid = 1'b1;
    sdram_readdata = 64'h1234_5678_9abc_def0;
    @(negedge clk_clk);
    chk("pop_issue", sdram_read, 1);
    chk("pop_wait", m_wait[0], 0);
    chk("pop_rdv", m_rdv, 2'b01);
    chk("pop_data", m_rdata[0], 64'h1234_5678_9abc_def0);
    cyc();
    m_read = 2'b00;
    // Remaining tags in issue order: m1, m0, m1, m0(stalled one), then empty.
    for (int j = 0; j < 5; j++) begin
      sdram_readdata = 64'(j);
      @(negedge clk_clk);
      chk("drain_rdv", m_rdv, (j == 4) ? 2'b00 : ((j % 2 == 0) ? 2'b10 : 2'b01));
      cyc();
    end
    sdram_readdatavalid = 1'b0;

    // Reset in the middle of a 4-beat write while m1 waits.
    do_reset();
    m_write[0] = 1'b1;
    m_bc[0] = 4;
    m_addr[0] = exp_addr(0, 300);
    m_wdata[0] = wdat(0, 300, 0);
    m_read[1] = 1'b1;
    m_addr[1] = exp_addr(1, 301);
    cyc();
    @(negedge clk_clk);
    chk("wb_beat1", sdram_write && !sdram_waitrequest, 1);
    chk("wb_m1_wait", m_wait[1], 1);
    cyc();
    m_wdata[0] = wdat(0, 300, 1);
    reset_reset_n = 1'b0;
    @(negedge clk_clk);
    chk("rst_mid_wr", sdram_write, 0);
    chk("rst_mid_wait", m_wait, 2'b11);
    cyc();
    m_write = 2'b00;
    m_read = 2'b00;
    reset_reset_n = 1'b1;
    cyc();
    sdram_readdatavalid = 1'b1;
    @(negedge clk_clk);
    chk("stale_rdv", m_rdv, 2'b00);
    chk("post_rst_wr", sdram_write, 0);
    cyc();
    sdram_readdatavalid = 1'b0;
    m_read[1] = 1'b1;
    m_bc[1] = 2;
    m_addr[1] = exp_addr(1, 302);
    @(negedge clk_clk);
    chk("idle_wait", m_wait, 2'b11);
    cyc();
    @(negedge clk_clk);
    chk("new_rd", sdram_read, 1);
    chk("new_bc", sdram_burstcount, 2);
    chk("new_addr", sdram_address, exp_addr(1, 302));
    chk("new_wait", m_wait, 2'b01);
    cyc();
    m_read = 2'b00;
    cyc();
    for (int j = 0; j < 3; j++) begin
      sdram_readdatavalid = 1'b1;
      @(negedge clk_clk);
      chk("new_rdv", m_rdv, (j < 2) ? 2'b10 : 2'b00);
      cyc();
    end
    sdram_readdatavalid = 1'b0;

    // Randomized traffic from both requesters.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      sidx[i] = 0; rx[i] = 0; exp_rx[i] = 0;
      for (int t = 0; t < NTR; t++) begin
        tr_wr[i][t] = 1'($urandom_range(0, 1));
        tr_bc[i][t] = BURST_W'($urandom_range(0, 4));
        if (!tr_wr[i][t]) exp_rx[i] += eff(tr_bc[i][t]);
      end
    end
    done = '0; stop = 1'b0; ret_busy = 1'b0; wr_rem = 0;
    fork
      run_req(0);
      run_req(1);
      run_slave();
      run_ret();
    join_none
    guard = 0;
    while (!(done == 2'b11 && rq.size() == 0 && !ret_busy && wr_rem == 0) && guard < 40000) begin
      cyc();
      guard++;
    end
    chk("rand_timeout", guard < 40000, 1);
    repeat (5) cyc();
    stop = 1'b1;
    repeat (3) cyc();
    chk("rand_cmds0", sidx[0], NTR);
    chk("rand_cmds1", sidx[1], NTR);
    chk("rand_rx0", rx[0], exp_rx[0]);
    chk("rand_rx1", rx[1], exp_rx[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
